// File: rtl/dmem_responder_if.sv
// LSU data-port bundle: req/gnt/rvalid handshake with request fields and response fields.
interface dmem_responder_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the LSU port: word SRAM with byte-enable writes,
// programmable grant wait-states and response latency, one transaction in flight.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int GNT_WAIT    = 0,
  parameter int RD_LATENCY  = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            gnt_stall_i,
  dmem_responder_if.slave bus
);
  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT_INIT  = 3'(RD_LATENCY - 1);
  localparam logic [3:0] WAIT_INIT = 4'(GNT_WAIT - 1);
  localparam bit         HAS_WAIT  = (GNT_WAIT != 32'sd0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [3:0]       wait_cnt_r, wait_cnt_s;
  logic [2:0]       lat_cnt_r, lat_cnt_s;
  logic             eligible_s;
  logic             resp_cycle_s;
  logic             gnt_s;
  logic             in_range_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      resp_data_r;
  logic             resp_err_r;
  logic [31:0]      mem_r [DEPTH_WORDS];
  logic             unused_s;

  // Range check on the full word index first, so the truncated index never aliases.
  assign in_range_s = (bus.data_addr[31:2] < 30'(DEPTH_WORDS));
  assign idx_s      = bus.data_addr[IDX_W+1:2];
  assign unused_s   = ^bus.data_addr[1:0];

  // State register with counters
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      lat_cnt_r  <= 3'd0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      lat_cnt_r  <= lat_cnt_s;
    end
  end

  // Next-state logic; the response cycle of BUSY behaves like IDLE for new requests
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    lat_cnt_s  = lat_cnt_r;
    if (gnt_s) begin
      state_s    = ST_BUSY;
      lat_cnt_s  = LAT_INIT;
      wait_cnt_s = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.data_req && HAS_WAIT) begin
            state_s    = ST_WAIT;
            wait_cnt_s = WAIT_INIT;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!bus.data_req) begin
            state_s = ST_IDLE;
          end else if (wait_cnt_r != 4'd0) begin
            wait_cnt_s = wait_cnt_r - 4'd1;
          end else begin
            wait_cnt_s = wait_cnt_r;
          end
        end
        ST_BUSY: begin
          if (resp_cycle_s) begin
            if (bus.data_req && HAS_WAIT) begin
              state_s    = ST_WAIT;
              wait_cnt_s = WAIT_INIT;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            lat_cnt_s = lat_cnt_r - 3'd1;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Output decode: grant gating and response presentation, all silenced in reset
  always_comb begin
    resp_cycle_s = rst_ni && (state_r == ST_BUSY) && (lat_cnt_r == 3'd0);
    case (state_r)
      ST_IDLE: eligible_s = !HAS_WAIT;
      ST_WAIT: eligible_s = (wait_cnt_r == 4'd0);
      ST_BUSY: eligible_s = resp_cycle_s && !HAS_WAIT;
      default: eligible_s = 1'b0;
    endcase
    gnt_s           = rst_ni & bus.data_req & eligible_s & ~gnt_stall_i;
    bus.data_gnt    = gnt_s;
    bus.data_rvalid = resp_cycle_s;
    if (resp_cycle_s) begin
      bus.data_rdata = resp_data_r;
      bus.data_err   = resp_err_r;
    end else begin
      bus.data_rdata = 32'h0;
      bus.data_err   = 1'b0;
    end
  end

  // Response capture at the grant edge; writes respond with zero data
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_data_r <= 32'h0;
      resp_err_r  <= 1'b0;
    end else if (gnt_s) begin
      resp_err_r <= ~in_range_s;
      if (!bus.data_we && in_range_s) begin
        resp_data_r <= mem_r[idx_s];
      end else begin
        resp_data_r <= 32'h0;
      end
    end else begin
      resp_data_r <= resp_data_r;
      resp_err_r  <= resp_err_r;
    end
  end

  // Byte-enable write port; array contents survive reset
  always_ff @(posedge clk_i) begin
    if (gnt_s && bus.data_we && in_range_s) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be[b]) begin
          mem_r[idx_s][8*b +: 8] <= bus.data_wdata[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A (no wait, latency 1, 1024 words)
// and instance B (3 wait-states, latency 4, 64 words).
module tb_dmem_responder;
  logic clk;
  logic rst_a, rst_b;
  logic stall_a, stall_b;
  int   n_checks;
  int   n_errors;

  dmem_responder_if ai();
  dmem_responder_if bi();

  dmem_responder #(.DEPTH_WORDS(1024), .GNT_WAIT(0), .RD_LATENCY(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_a), .gnt_stall_i(stall_a), .bus(ai)
  );

  dmem_responder #(.DEPTH_WORDS(64), .GNT_WAIT(3), .RD_LATENCY(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_b), .gnt_stall_i(stall_b), .bus(bi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic a_drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
    ai.data_req   = req;
    ai.data_we    = we;
    ai.data_addr  = addr;
    ai.data_be    = be;
    ai.data_wdata = wdata;
  endtask

  task automatic b_drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
    bi.data_req   = req;
    bi.data_we    = we;
    bi.data_addr  = addr;
    bi.data_be    = be;
    bi.data_wdata = wdata;
  endtask

  // Instance A: gnt in the request cycle, response exactly one cycle later.
  task automatic a_xfer(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    a_drive(1'b1, we, addr, be, wdata);
    #1;
    check_eq({tag, "_gnt"}, 32'(ai.data_gnt), 32'd1);
    check_eq({tag, "_rv_early"}, 32'(ai.data_rvalid), 32'd0);
    @(negedge clk);
    ai.data_req = 1'b0;
    #1;
    check_eq({tag, "_rvalid"}, 32'(ai.data_rvalid), 32'd1);
    check_eq({tag, "_rdata"}, ai.data_rdata, exp_rdata);
    check_eq({tag, "_err"}, 32'(ai.data_err), 32'(exp_err));
  endtask

  // Instance B: gnt after 3 held cycles, one rvalid exactly 4 cycles after gnt.
  task automatic b_xfer(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int gnt_at;
    int rv_at;
    int rv_cnt;
    logic [31:0] rd;
    logic er;
    gnt_at = -1;
    rv_at  = -1;
    rv_cnt = 0;
    rd     = 32'h0;
    er     = 1'b0;
    @(negedge clk);
    b_drive(1'b1, we, addr, be, wdata);
    for (int c = 0; c < 16 && gnt_at < 0; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bi.data_gnt) gnt_at = c;
    end
    check_eq({tag, "_gnt_at"}, 32'(gnt_at), 32'd3);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bi.data_req = 1'b0;
      #1;
      if (bi.data_rvalid) begin
        rv_cnt++;
        if (rv_at < 0) begin
          rv_at = c;
          rd    = bi.data_rdata;
          er    = bi.data_err;
        end
      end
    end
    check_eq({tag, "_rv_at"}, 32'(rv_at), 32'd4);
    check_eq({tag, "_rv_cnt"}, 32'(rv_cnt), 32'd1);
    check_eq({tag, "_rdata"}, rd, exp_rdata);
    check_eq({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gnt_at;
    int rv_cnt;
    n_checks = 0;
    n_errors = 0;
    clk      = 1'b0;
    rst_a    = 1'b0;
    rst_b    = 1'b0;
    stall_a  = 1'b0;
    stall_b  = 1'b0;
    a_drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    b_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_gnt", 32'(ai.data_gnt), 32'd0);
    check_eq("rst_rvalid", 32'(ai.data_rvalid), 32'd0);
    check_eq("rst_rdata", ai.data_rdata, 32'h0);
    check_eq("rst_err", 32'(ai.data_err), 32'd0);
    @(negedge clk);
    ai.data_req = 1'b0;
    rst_a       = 1'b1;
    rst_b       = 1'b1;

    a_xfer("wr10",      1'b1, 32'h10,   4'hF, 32'hA5A5_1234, 32'h0,         1'b0);
    a_xfer("rd10",      1'b0, 32'h10,   4'h0, 32'h0,         32'hA5A5_1234, 1'b0);
    a_xfer("wr20_ff",   1'b1, 32'h20,   4'hF, 32'hFFFF_FFFF, 32'h0,         1'b0);
    a_xfer("wr20_part", 1'b1, 32'h20,   4'h5, 32'h0000_0000, 32'h0,         1'b0);
    a_xfer("rd22",      0,    32'h22,   4'h0, 32'h0,         32'hFF00_FF00, 1'b0);
    a_xfer("wr0",       1'b1, 32'h0,    4'hF, 32'h1111_1111, 32'h0,         1'b0);
    a_xfer("wr_oor",    1'b1, 32'h1000, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b1);
    a_xfer("rd_oor",    1'b0, 32'h1000, 4'h0, 32'h0,         32'h0,         1'b1);
    a_xfer("rd0_alias", 1'b0, 32'h0,    4'h0, 32'h0,         32'h1111_1111, 1'b0);
    a_xfer("wr_last",   1'b1, 32'hFFC,  4'hF, 32'h5A5A_5A5A, 32'h0,         1'b0);
    a_xfer("rd_last",   1'b0, 32'hFFC,  4'h0, 32'h0,         32'h5A5A_5A5A, 1'b0);

    // Stall hook holds off an eligible request, grant follows release in the same cycle.
    @(negedge clk);
    stall_a = 1'b1;
    a_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check_eq("stall_gnt", 32'(ai.data_gnt), 32'd0);
      check_eq("stall_rvalid", 32'(ai.data_rvalid), 32'd0);
    end
    @(negedge clk);
    stall_a = 1'b0;
    #1;
    check_eq("unstall_gnt", 32'(ai.data_gnt), 32'd1);
    @(negedge clk);
    ai.data_req = 1'b0;
    #1;
    check_eq("unstall_rvalid", 32'(ai.data_rvalid), 32'd1);
    check_eq("unstall_rdata", ai.data_rdata, 32'hA5A5_1234);

    // Back-to-back: second grant coincides with the first response.
    @(negedge clk);
    a_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    #1;
    check_eq("b2b_gnt1", 32'(ai.data_gnt), 32'd1);
    @(negedge clk);
    a_drive(1'b1, 1'b0, 32'h22, 4'h0, 32'h0);
    #1;
    check_eq("b2b_gnt2", 32'(ai.data_gnt), 32'd1);
    check_eq("b2b_rv1", 32'(ai.data_rvalid), 32'd1);
    check_eq("b2b_rd1", ai.data_rdata, 32'hA5A5_1234);
    @(negedge clk);
    ai.data_req = 1'b0;
    #1;
    check_eq("b2b_rv2", 32'(ai.data_rvalid), 32'd1);
    check_eq("b2b_rd2", ai.data_rdata, 32'hFF00_FF00);
    @(negedge clk);
    #1;
    check_eq("b2b_pulse", 32'(ai.data_rvalid), 32'd0);

    b_xfer("b_wr8", 1'b1, 32'h8, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
    b_xfer("b_rd8", 1'b0, 32'h8, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Reset two cycles after a read grant drops the pending response.
    @(negedge clk);
    b_drive(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    gnt_at = -1;
    for (int c = 0; c < 16 && gnt_at < 0; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bi.data_gnt) gnt_at = c;
    end
    check_eq("midrst_gnt_at", 32'(gnt_at), 32'd3);
    @(negedge clk);
    bi.data_req = 1'b0;
    @(negedge clk);
    rst_b       = 1'b0;
    bi.data_req = 1'b1;
    #1;
    check_eq("midrst_gnt", 32'(bi.data_gnt), 32'd0);
    check_eq("midrst_rvalid", 32'(bi.data_rvalid), 32'd0);
    check_eq("midrst_rdata", bi.data_rdata, 32'h0);
    check_eq("midrst_err", 32'(bi.data_err), 32'd0);
    @(negedge clk);
    rst_b       = 1'b1;
    bi.data_req = 1'b0;
    rv_cnt      = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bi.data_rvalid) rv_cnt++;
    end
    check_eq("midrst_no_rvalid", 32'(rv_cnt), 32'd0);

    b_xfer("b_rd8_post", 1'b0, 32'h8,   4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
    b_xfer("b_rd_oor",   1'b0, 32'h100, 4'h0, 32'h0, 32'h0,         1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
